// File: rtl/ex_stage_pkg.sv
// Shared types for the RV32I execute stage: instruction-type codes, bus widths and the EX/MEM payload.
package ex_stage_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned INST_TYPE_W = 6;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam word_t ZERO_WORD = '0;

    typedef enum logic [INST_TYPE_W-1:0] {
        INST_NOP   = 6'd0,
        INST_LUI   = 6'd1,  INST_AUIPC = 6'd2,  INST_JAL   = 6'd3,  INST_JALR  = 6'd4,
        INST_BEQ   = 6'd5,  INST_BNE   = 6'd6,  INST_BLT   = 6'd7,  INST_BGE   = 6'd8,
        INST_BLTU  = 6'd9,  INST_BGEU  = 6'd10,
        INST_LB    = 6'd11, INST_LH    = 6'd12, INST_LW    = 6'd13, INST_LBU   = 6'd14,
        INST_LHU   = 6'd15,
        INST_SB    = 6'd16, INST_SH    = 6'd17, INST_SW    = 6'd18,
        INST_ADDI  = 6'd19, INST_SLTI  = 6'd20, INST_SLTIU = 6'd21, INST_XORI  = 6'd22,
        INST_ORI   = 6'd23, INST_ANDI  = 6'd24, INST_SLLI  = 6'd25, INST_SRLI  = 6'd26,
        INST_SRAI  = 6'd27,
        INST_ADD   = 6'd28, INST_SUB   = 6'd29, INST_SLL   = 6'd30, INST_SLT   = 6'd31,
        INST_SLTU  = 6'd32, INST_XOR   = 6'd33, INST_SRL   = 6'd34, INST_SRA   = 6'd35,
        INST_OR    = 6'd36, INST_AND   = 6'd37
    } inst_type_t;

    typedef struct packed {
        logic       valid;
        logic       rd_we;
        reg_addr_t  rd_addr;
        word_t      rd_val;
        inst_type_t inst_type;
        word_t      mem_addr;
        word_t      mem_wdata;
    } ex_mem_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '{
        valid: 1'b0, rd_we: 1'b0, rd_addr: '0, rd_val: ZERO_WORD,
        inst_type: INST_NOP, mem_addr: ZERO_WORD, mem_wdata: ZERO_WORD
    };

    // Register-register ALU ops take rs2 as the second operand; everything else uses imm.
    function automatic logic is_reg_op(input inst_type_t t);
        return t inside {INST_ADD, INST_SUB, INST_SLL, INST_SLT, INST_SLTU,
                         INST_XOR, INST_SRL, INST_SRA, INST_OR, INST_AND};
    endfunction

    function automatic logic is_store(input inst_type_t t);
        return t inside {INST_SB, INST_SH, INST_SW};
    endfunction

    function automatic logic is_load(input inst_type_t t);
        return t inside {INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU};
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational execute datapath: ALU result, effective address and branch/jump resolution.
module ex_alu
    import ex_stage_pkg::*;
(
    input  inst_type_t inst_type,
    input  word_t      rs1,
    input  word_t      rs2,
    input  word_t      imm,
    input  word_t      pc,
    output word_t      rd_val,
    output word_t      mem_addr,
    output logic       taken,
    output word_t      target
);

    word_t      op_b;
    word_t      pc_imm;
    word_t      rs1_imm;
    logic [4:0] shamt;

    assign op_b    = is_reg_op(inst_type) ? rs2 : imm;
    assign pc_imm  = pc + imm;
    assign rs1_imm = rs1 + imm;
    assign shamt   = op_b[4:0];

    always_comb begin
        rd_val   = ZERO_WORD;
        mem_addr = ZERO_WORD;
        taken    = 1'b0;
        target   = ZERO_WORD;
        unique case (inst_type)
            INST_LUI:   rd_val = imm;
            INST_AUIPC: rd_val = pc_imm;
            INST_JAL: begin
                rd_val = pc + 32'd4;
                taken  = 1'b1;
                target = pc_imm;
            end
            INST_JALR: begin
                rd_val = pc + 32'd4;
                taken  = 1'b1;
                target = {rs1_imm[XLEN-1:1], 1'b0};
            end
            INST_BEQ:  begin taken = (rs1 == rs2);                   target = pc_imm; end
            INST_BNE:  begin taken = (rs1 != rs2);                   target = pc_imm; end
            INST_BLT:  begin taken = ($signed(rs1) <  $signed(rs2)); target = pc_imm; end
            INST_BGE:  begin taken = ($signed(rs1) >= $signed(rs2)); target = pc_imm; end
            INST_BLTU: begin taken = (rs1 <  rs2);                   target = pc_imm; end
            INST_BGEU: begin taken = (rs1 >= rs2);                   target = pc_imm; end
            INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU,
            INST_SB, INST_SH, INST_SW:
                mem_addr = rs1_imm;
            INST_ADD, INST_ADDI:   rd_val = rs1 + op_b;
            INST_SUB:              rd_val = rs1 - rs2;
            INST_SLL, INST_SLLI:   rd_val = rs1 << shamt;
            INST_SRL, INST_SRLI:   rd_val = rs1 >> shamt;
            INST_SRA, INST_SRAI:   rd_val = word_t'($signed(rs1) >>> shamt);
            INST_SLT, INST_SLTI:   rd_val = word_t'($signed(rs1) < $signed(op_b));
            INST_SLTU, INST_SLTIU: rd_val = word_t'(rs1 < op_b);
            INST_XOR, INST_XORI:   rd_val = rs1 ^ op_b;
            INST_OR, INST_ORI:     rd_val = rs1 | op_b;
            INST_AND, INST_ANDI:   rd_val = rs1 & op_b;
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: EX/MEM result register, redirect pulse and wrong-path squash FSM.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned SQUASH_SLOTS = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       valid_ex_in,
    input  word_t      rs1_ex_in,
    input  word_t      rs2_ex_in,
    input  logic       rd_ex_in,
    input  reg_addr_t  rd_addr_ex_in,
    input  inst_type_t inst_type_ex_in,
    input  word_t      imm_ex_in,
    input  word_t      pc_ex_in,
    input  logic       stall_mem_in,
    output logic       stall_ex_out,
    output logic       valid_mem_out,
    output logic       rd_we_mem_out,
    output reg_addr_t  rd_addr_mem_out,
    output word_t      rd_val_mem_out,
    output inst_type_t inst_type_mem_out,
    output word_t      mem_addr_mem_out,
    output word_t      mem_wdata_mem_out,
    output logic       branch_taken_out,
    output word_t      branch_target_out
);

    localparam int unsigned CNT_W = (SQUASH_SLOTS > 0) ? $clog2(SQUASH_SLOTS + 1) : 1;

    typedef enum logic {ST_RUN, ST_SQUASH} state_t;

    state_t     state;
    logic [CNT_W-1:0] cnt;
    ex_mem_t    ex_mem_q;
    ex_mem_t    ex_mem_d;
    word_t      alu_rd_val;
    word_t      alu_mem_addr;
    word_t      alu_target;
    logic       alu_taken;

    ex_alu u_alu (
        .inst_type (inst_type_ex_in),
        .rs1       (rs1_ex_in),
        .rs2       (rs2_ex_in),
        .imm       (imm_ex_in),
        .pc        (pc_ex_in),
        .rd_val    (alu_rd_val),
        .mem_addr  (alu_mem_addr),
        .taken     (alu_taken),
        .target    (alu_target)
    );

    assign stall_ex_out = stall_mem_in;

    always_comb begin
        ex_mem_d           = EX_MEM_BUBBLE;
        ex_mem_d.valid     = 1'b1;
        ex_mem_d.rd_we     = rd_ex_in && (rd_addr_ex_in != '0);
        ex_mem_d.rd_addr   = rd_addr_ex_in;
        ex_mem_d.rd_val    = alu_rd_val;
        ex_mem_d.inst_type = inst_type_ex_in;
        ex_mem_d.mem_addr  = alu_mem_addr;
        ex_mem_d.mem_wdata = is_store(inst_type_ex_in) ? rs2_ex_in : ZERO_WORD;
    end

    // Nothing advances while memory stalls, except the redirect pulse which always self-clears.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= ST_RUN;
            cnt               <= '0;
            ex_mem_q          <= EX_MEM_BUBBLE;
            branch_taken_out  <= 1'b0;
            branch_target_out <= ZERO_WORD;
        end else begin
            branch_taken_out <= 1'b0;
            if (!stall_mem_in) begin
                if (!valid_ex_in) begin
                    ex_mem_q <= EX_MEM_BUBBLE;
                end else if (state == ST_SQUASH) begin
                    ex_mem_q <= EX_MEM_BUBBLE;
                    cnt      <= cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state <= ST_RUN;
                    end
                end else begin
                    ex_mem_q <= ex_mem_d;
                    if (alu_taken) begin
                        branch_taken_out  <= 1'b1;
                        branch_target_out <= alu_target;
                        if (SQUASH_SLOTS != 0) begin
                            cnt   <= CNT_W'(SQUASH_SLOTS);
                            state <= ST_SQUASH;
                        end
                    end
                end
            end
        end
    end

    assign valid_mem_out     = ex_mem_q.valid;
    assign rd_we_mem_out     = ex_mem_q.rd_we;
    assign rd_addr_mem_out   = ex_mem_q.rd_addr;
    assign rd_val_mem_out    = ex_mem_q.rd_val;
    assign inst_type_mem_out = ex_mem_q.inst_type;
    assign mem_addr_mem_out  = ex_mem_q.mem_addr;
    assign mem_wdata_mem_out = ex_mem_q.mem_wdata;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for datapath ops, hand sequences for redirect, squash, stall and reset.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       valid_ex_in;
    word_t      rs1_ex_in, rs2_ex_in, imm_ex_in, pc_ex_in;
    logic       rd_ex_in;
    reg_addr_t  rd_addr_ex_in;
    inst_type_t inst_type_ex_in;
    logic       stall_mem_in;
    logic       stall_ex_out, valid_mem_out, rd_we_mem_out, branch_taken_out;
    reg_addr_t  rd_addr_mem_out;
    word_t      rd_val_mem_out, mem_addr_mem_out, mem_wdata_mem_out, branch_target_out;
    inst_type_t inst_type_mem_out;

    int checks = 0;
    int errors = 0;

    ex_stage #(.SQUASH_SLOTS(1)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .valid_ex_in       (valid_ex_in),
        .rs1_ex_in         (rs1_ex_in),
        .rs2_ex_in         (rs2_ex_in),
        .rd_ex_in          (rd_ex_in),
        .rd_addr_ex_in     (rd_addr_ex_in),
        .inst_type_ex_in   (inst_type_ex_in),
        .imm_ex_in         (imm_ex_in),
        .pc_ex_in          (pc_ex_in),
        .stall_mem_in      (stall_mem_in),
        .stall_ex_out      (stall_ex_out),
        .valid_mem_out     (valid_mem_out),
        .rd_we_mem_out     (rd_we_mem_out),
        .rd_addr_mem_out   (rd_addr_mem_out),
        .rd_val_mem_out    (rd_val_mem_out),
        .inst_type_mem_out (inst_type_mem_out),
        .mem_addr_mem_out  (mem_addr_mem_out),
        .mem_wdata_mem_out (mem_wdata_mem_out),
        .branch_taken_out  (branch_taken_out),
        .branch_target_out (branch_target_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        inst_type_t t;
        word_t      rs1, rs2, imm, pc;
        logic       we;
        reg_addr_t  rd;
        word_t      e_val, e_addr, e_wdata;
        logic       e_we;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input inst_type_t t, input word_t rs1, input word_t rs2,
                         input word_t imm, input word_t pc, input logic we, input reg_addr_t rd);
        valid_ex_in     = v;
        inst_type_ex_in = t;
        rs1_ex_in       = rs1;
        rs2_ex_in       = rs2;
        imm_ex_in       = imm;
        pc_ex_in        = pc;
        rd_ex_in        = we;
        rd_addr_ex_in   = rd;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " valid"},     32'(valid_mem_out), 32'd0);
        check({tag, " rd_we"},     32'(rd_we_mem_out), 32'd0);
        check({tag, " rd_addr"},   32'(rd_addr_mem_out), 32'd0);
        check({tag, " rd_val"},    rd_val_mem_out, 32'd0);
        check({tag, " inst_type"}, 32'(inst_type_mem_out), 32'(INST_NOP));
        check({tag, " mem_addr"},  mem_addr_mem_out, 32'd0);
        check({tag, " wdata"},     mem_wdata_mem_out, 32'd0);
        check({tag, " taken"},     32'(branch_taken_out), 32'd0);
        check({tag, " target"},    branch_target_out, 32'd0);
    endtask

    initial begin
        vecs.push_back('{INST_ADD,   32'h7FFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1, 5'd5, 32'h80000000, 32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_SRA,   32'h80000000, 32'h21,       32'h0,        32'h0,        1'b1, 5'd6, 32'hC0000000, 32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_SUB,   32'h5,        32'h7,        32'h0,        32'h0,        1'b1, 5'd7, 32'hFFFFFFFE, 32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_SLT,   32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1, 5'd8, 32'h1,        32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1, 5'd8, 32'h0,        32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_SLTIU, 32'h1,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b1, 5'd9, 32'h1,        32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_SRLI,  32'h80000000, 32'h0,        32'h1F,       32'h0,        1'b1, 5'd9, 32'h1,        32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_SLL,   32'h1,        32'h3F,       32'h0,        32'h0,        1'b1, 5'd9, 32'h80000000, 32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_XORI,  32'hFF00FF00, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b1, 5'd1, 32'h00FF00FF, 32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_AND,   32'hF0F0,     32'hFF00,     32'h0,        32'h0,        1'b1, 5'd2, 32'hF000,     32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_LUI,   32'h0,        32'h0,        32'h12345000, 32'h0,        1'b1, 5'd3, 32'h12345000, 32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_AUIPC, 32'h0,        32'h0,        32'h2000,     32'hFFFFF000, 1'b1, 5'd3, 32'h00001000, 32'h0,   32'h0,        1'b1});
        vecs.push_back('{INST_LW,    32'h1000,     32'h55,       32'hFFFFFFFC, 32'h0,        1'b1, 5'd7, 32'h0,        32'hFFC, 32'h0,        1'b1});
        vecs.push_back('{INST_SW,    32'h200,      32'hDEADBEEF, 32'h8,        32'h0,        1'b0, 5'd0, 32'h0,        32'h208, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{INST_ADDI,  32'h3,        32'h0,        32'h4,        32'h0,        1'b1, 5'd0, 32'h7,        32'h0,   32'h0,        1'b0});
        vecs.push_back('{INST_BGE,   32'hFFFFFFFF, 32'h1,        32'h40,       32'h100,      1'b0, 5'd0, 32'h0,        32'h0,   32'h0,        1'b0});
        vecs.push_back('{INST_BLTU,  32'hFFFFFFFF, 32'h1,        32'h40,       32'h100,      1'b0, 5'd0, 32'h0,        32'h0,   32'h0,        1'b0});
        vecs.push_back('{INST_BNE,   32'h9,        32'h9,        32'h40,       32'h100,      1'b0, 5'd0, 32'h0,        32'h0,   32'h0,        1'b0});
        vecs.push_back('{INST_BGEU,  32'h1,        32'hFFFFFFFF, 32'h40,       32'h100,      1'b0, 5'd0, 32'h0,        32'h0,   32'h0,        1'b0});

        rst_in       = 1'b0;
        stall_mem_in = 1'b0;
        drive(1'b0, INST_NOP, 0, 0, 0, 0, 1'b0, 5'd0);
        #12;
        check_reset_outputs("reset");
        check("reset stall_ex", 32'(stall_ex_out), 32'd0);
        rst_in = 1'b1;

        // Datapath table, all non-redirecting so the FSM stays in RUN.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].t, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc, vecs[i].we, vecs[i].rd);
            tick();
            check($sformatf("vec%0d valid", i),     32'(valid_mem_out), 32'd1);
            check($sformatf("vec%0d rd_we", i),     32'(rd_we_mem_out), 32'(vecs[i].e_we));
            check($sformatf("vec%0d rd_addr", i),   32'(rd_addr_mem_out), 32'(vecs[i].rd));
            check($sformatf("vec%0d rd_val", i),    rd_val_mem_out, vecs[i].e_val);
            check($sformatf("vec%0d mem_addr", i),  mem_addr_mem_out, vecs[i].e_addr);
            check($sformatf("vec%0d wdata", i),     mem_wdata_mem_out, vecs[i].e_wdata);
            check($sformatf("vec%0d inst_type", i), 32'(inst_type_mem_out), 32'(vecs[i].t));
            check($sformatf("vec%0d taken", i),     32'(branch_taken_out), 32'd0);
        end

        // Bubble clears valid/we/addr and sets NOP.
        drive(1'b0, INST_ADD, 1, 1, 0, 0, 1'b1, 5'd9);
        tick();
        check("bubble valid", 32'(valid_mem_out), 32'd0);
        check("bubble rd_we", 32'(rd_we_mem_out), 32'd0);
        check("bubble rd_addr", 32'(rd_addr_mem_out), 32'd0);
        check("bubble inst_type", 32'(inst_type_mem_out), 32'(INST_NOP));

        // BLT taken, next valid squashed, following one kept.
        drive(1'b1, INST_BLT, 32'hFFFFFFFF, 32'h1, 32'h20, 32'h100, 1'b0, 5'd0);
        tick();
        check("blt taken", 32'(branch_taken_out), 32'd1);
        check("blt target", branch_target_out, 32'h120);
        check("blt valid", 32'(valid_mem_out), 32'd1);
        check("blt rd_val", rd_val_mem_out, 32'h0);
        drive(1'b1, INST_ADDI, 32'h1, 32'h0, 32'h2, 32'h104, 1'b1, 5'd3);
        tick();
        check("blt squash valid", 32'(valid_mem_out), 32'd0);
        check("blt squash rd_we", 32'(rd_we_mem_out), 32'd0);
        check("blt pulse end", 32'(branch_taken_out), 32'd0);
        drive(1'b1, INST_ADDI, 32'hA, 32'h0, 32'h5, 32'h120, 1'b1, 5'd4);
        tick();
        check("blt keep valid", 32'(valid_mem_out), 32'd1);
        check("blt keep rd_val", rd_val_mem_out, 32'hF);
        check("blt target hold", branch_target_out, 32'h120);

        // JALR, then a bubble (no decrement), then a taken BEQ that is squashed.
        drive(1'b1, INST_JALR, 32'h203, 32'h0, 32'h0, 32'h40, 1'b1, 5'd1);
        tick();
        check("jalr taken", 32'(branch_taken_out), 32'd1);
        check("jalr target", branch_target_out, 32'h202);
        check("jalr rd_val", rd_val_mem_out, 32'h44);
        check("jalr rd_we", 32'(rd_we_mem_out), 32'd1);
        drive(1'b0, INST_NOP, 0, 0, 0, 0, 1'b0, 5'd0);
        tick();
        check("jalr pulse end", 32'(branch_taken_out), 32'd0);
        check("jalr bubble valid", 32'(valid_mem_out), 32'd0);
        drive(1'b1, INST_BEQ, 32'h5, 32'h5, 32'h10, 32'h300, 1'b0, 5'd0);
        tick();
        check("beq squash valid", 32'(valid_mem_out), 32'd0);
        check("beq squash taken", 32'(branch_taken_out), 32'd0);
        check("beq squash target", branch_target_out, 32'h202);
        drive(1'b1, INST_ADDI, 32'h1, 32'h0, 32'h1, 32'h204, 1'b1, 5'd2);
        tick();
        check("post beq keep valid", 32'(valid_mem_out), 32'd1);
        check("post beq rd_val", rd_val_mem_out, 32'h2);
        check("post beq taken", 32'(branch_taken_out), 32'd0);

        // JAL pulse stays one cycle even when stall rises right after.
        drive(1'b1, INST_JAL, 32'h0, 32'h0, 32'h100, 32'h80, 1'b1, 5'd1);
        tick();
        check("jal taken", 32'(branch_taken_out), 32'd1);
        check("jal target", branch_target_out, 32'h180);
        check("jal rd_val", rd_val_mem_out, 32'h84);
        stall_mem_in = 1'b1;
        drive(1'b1, INST_ADDI, 32'h1, 32'h0, 32'h1, 32'h84, 1'b1, 5'd2);
        #1;
        check("jal taken under stall", 32'(branch_taken_out), 32'd1);
        tick();
        check("jal pulse end stall", 32'(branch_taken_out), 32'd0);
        check("jal hold rd_val", rd_val_mem_out, 32'h84);
        stall_mem_in = 1'b0;
        tick();
        check("jal squash valid", 32'(valid_mem_out), 32'd0);
        drive(1'b1, INST_ADDI, 32'h10, 32'h0, 32'h5, 32'h180, 1'b1, 5'd4);
        tick();
        check("jal keep valid", 32'(valid_mem_out), 32'd1);
        check("jal keep rd_val", rd_val_mem_out, 32'h15);

        // SW held for three stalled cycles.
        stall_mem_in = 1'b1;
        drive(1'b1, INST_SW, 32'h400, 32'hCAFEF00D, 32'hC, 32'h184, 1'b0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d stall_ex", k), 32'(stall_ex_out), 32'd1);
            check($sformatf("stall%0d valid", k), 32'(valid_mem_out), 32'd1);
            check($sformatf("stall%0d rd_val", k), rd_val_mem_out, 32'h15);
            check($sformatf("stall%0d inst_type", k), 32'(inst_type_mem_out), 32'(INST_ADDI));
        end
        stall_mem_in = 1'b0;
        tick();
        check("sw stall_ex", 32'(stall_ex_out), 32'd0);
        check("sw inst_type", 32'(inst_type_mem_out), 32'(INST_SW));
        check("sw mem_addr", mem_addr_mem_out, 32'h40C);
        check("sw wdata", mem_wdata_mem_out, 32'hCAFEF00D);
        check("sw rd_we", 32'(rd_we_mem_out), 32'd0);
        check("sw valid", 32'(valid_mem_out), 32'd1);

        // Asynchronous reset mid-SQUASH, then the next valid must be kept.
        drive(1'b1, INST_JAL, 32'h0, 32'h0, 32'h8, 32'h500, 1'b1, 5'd1);
        tick();
        check("pre-reset taken", 32'(branch_taken_out), 32'd1);
        drive(1'b0, INST_NOP, 0, 0, 0, 0, 1'b0, 5'd0);
        #2;
        rst_in = 1'b0;
        #1;
        check_reset_outputs("midreset");
        rst_in = 1'b1;
        drive(1'b1, INST_ADDI, 32'h20, 32'h0, 32'h2, 32'h600, 1'b1, 5'd6);
        tick();
        check("after reset valid", 32'(valid_mem_out), 32'd1);
        check("after reset rd_val", rd_val_mem_out, 32'h22);
        check("after reset taken", 32'(branch_taken_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
